// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared LSU definitions: FSM states, RISC-V funct3 load/store encodings and
// size decode helpers.
package ysyx_24100005_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Low address bits that must be zero for an access of this size.
  function automatic logic [2:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    size_mask = 3'b000;
      2'd1:    size_mask = 3'b001;
      2'd2:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] funct3, input logic we,
                                    input int unsigned xlen);
    f3_legal = 1'b1;
    if (funct3 == 3'b111) begin
      f3_legal = 1'b0;
    end else if (we) begin
      if (funct3[2] || (funct3 == F3_D && xlen == 32)) f3_legal = 1'b0;
    end else begin
      if ((funct3 == F3_D || funct3 == F3_WU) && xlen == 32) f3_legal = 1'b0;
    end
  endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// Byte-lane steering: store data shift / write-mask generation and load
// lane extraction with sign or zero extension.
module ysyx_24100005_lsu_align
  import ysyx_24100005_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]                  funct3,
  input  logic [$clog2(XLEN/8)-1:0]   offset,
  input  logic [XLEN-1:0]             st_data,
  input  logic [XLEN-1:0]             ld_word,
  output logic [XLEN-1:0]             st_wdata,
  output logic [XLEN/8-1:0]           st_wmask,
  output logic [XLEN-1:0]             ld_data
);

  localparam int unsigned OFFW = $clog2(XLEN/8);
  localparam int unsigned MW   = XLEN/8;

  logic [OFFW+2:0] bit_sh;
  logic [XLEN-1:0] st_trunc;
  logic [XLEN-1:0] ld_sh;
  logic [MW-1:0]   st_bmask;

  assign bit_sh = {offset, 3'b000};

  always_comb begin
    st_trunc = '0;
    st_bmask = '0;
    case (funct3[1:0])
      2'd0: begin
        st_trunc = XLEN'(st_data[7:0]);
        st_bmask = MW'(8'h01);
      end
      2'd1: begin
        st_trunc = XLEN'(st_data[15:0]);
        st_bmask = MW'(8'h03);
      end
      2'd2: begin
        st_trunc = XLEN'(st_data[31:0]);
        st_bmask = MW'(8'h0F);
      end
      default: begin
        st_trunc = st_data;
        st_bmask = '1;
      end
    endcase
  end

  assign st_wdata = st_trunc << bit_sh;
  assign st_wmask = st_bmask << offset;
  assign ld_sh    = ld_word >> bit_sh;

  always_comb begin
    ld_data = '0;
    case (funct3)
      F3_B:    ld_data = XLEN'($signed(ld_sh[7:0]));
      F3_H:    ld_data = XLEN'($signed(ld_sh[15:0]));
      F3_W:    ld_data = XLEN'($signed(ld_sh[31:0]));
      F3_D:    ld_data = ld_sh;
      F3_BU:   ld_data = XLEN'(ld_sh[7:0]);
      F3_HU:   ld_data = XLEN'(ld_sh[15:0]);
      F3_WU:   ld_data = XLEN'(ld_sh[31:0]);
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Load/store unit: IDLE -> BUSY -> RESP handshake to a word-wide memory port.
// Define YSYX_24100005_LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
module ysyx_24100005_lsu
  import ysyx_24100005_lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wmask,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int unsigned OFFW    = $clog2(XLEN/8);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT) - 32'd1;

  lsu_state_e        state_q, state_d;
  logic [31:0]       cnt_q;
  logic              lat_we;
  logic [2:0]        lat_f3;
  logic [31:0]       lat_addr;
  logic [XLEN-1:0]   lat_wdata;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic              rsp_err_q;
  logic              req_bad, accept, busy, timeout_hit;
  logic [OFFW-1:0]   lane_off;
  logic [XLEN-1:0]   st_wdata, ld_data;
  logic [XLEN/8-1:0] st_wmask;

  always_comb begin
    req_bad = !f3_legal(req_funct3, req_we, XLEN);
`ifdef YSYX_24100005_LSU_MISALIGN_TRAP_EN
    if ((req_addr[2:0] & size_mask(req_funct3)) != 3'b000) req_bad = 1'b1;
`endif
  end

  assign busy        = (state_q == S_BUSY);
  assign accept      = (state_q == S_IDLE) && req_valid;
  assign timeout_hit = busy && !mem_ack && (TIMEOUT != 0) && (cnt_q == TO_LAST);
  // Misaligned accesses that are not trapped use the size-aligned lane.
  assign lane_off    = lat_addr[OFFW-1:0] & OFFW'(~size_mask(lat_f3));

  ysyx_24100005_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3   (lat_f3),
    .offset   (lane_off),
    .st_data  (lat_wdata),
    .ld_word  (mem_rdata),
    .st_wdata (st_wdata),
    .st_wmask (st_wmask),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_bad ? S_RESP : S_BUSY;
      end
      S_BUSY: begin
        mem_req  = 1'b1;
        mem_we   = lat_we;
        mem_addr = {lat_addr[31:OFFW], {OFFW{1'b0}}};
        if (lat_we) begin
          mem_wdata = st_wdata;
          mem_wmask = st_wmask;
        end
        if (mem_ack || timeout_hit) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rsp_rdata_q;
        resp_err   = rsp_err_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_we      <= 1'b0;
      lat_f3      <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lat_we      <= req_we;
        lat_f3      <= req_funct3;
        lat_addr    <= req_addr;
        lat_wdata   <= req_wdata;
        cnt_q       <= '0;
        rsp_rdata_q <= '0;
        rsp_err_q   <= req_bad;
      end else if (busy) begin
        if (mem_ack) begin
          rsp_rdata_q <= lat_we ? '0 : ld_data;
          rsp_err_q   <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 32'd1;
          if (timeout_hit) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Scoreboard bench for ysyx_24100005_lsu: XLEN=32/TIMEOUT=4 main instance,
// a TIMEOUT=0 instance and an XLEN=64 instance.
module tb_ysyx_24100005_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_t;

  logic clk, rst;
  int   total = 0;
  int   bad   = 0;

  // Instance A: XLEN=32, TIMEOUT=4
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic        a_mem_req, a_mem_we, a_mem_ack;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_wmask;

  // Instance B: XLEN=32, TIMEOUT=0
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic        b_mem_req, b_mem_we, b_mem_ack;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wmask;

  // Instance C: XLEN=64
  logic        c_req_valid, c_req_ready, c_req_we;
  logic [2:0]  c_req_funct3;
  logic [31:0] c_req_addr;
  logic [63:0] c_req_wdata;
  logic        c_resp_valid, c_resp_err;
  logic [63:0] c_resp_rdata;
  logic        c_mem_req, c_mem_we, c_mem_ack;
  logic [31:0] c_mem_addr;
  logic [63:0] c_mem_wdata, c_mem_rdata;
  logic [7:0]  c_mem_wmask;

  ysyx_24100005_lsu #(.XLEN(32), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask), .mem_ack(a_mem_ack),
    .mem_rdata(a_mem_rdata)
  );

  ysyx_24100005_lsu #(.XLEN(32), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_ack(b_mem_ack),
    .mem_rdata(b_mem_rdata)
  );

  ysyx_24100005_lsu #(.XLEN(64)) dut_c (
    .clk(clk), .rst(rst),
    .req_valid(c_req_valid), .req_ready(c_req_ready), .req_we(c_req_we),
    .req_funct3(c_req_funct3), .req_addr(c_req_addr), .req_wdata(c_req_wdata),
    .resp_valid(c_resp_valid), .resp_rdata(c_resp_rdata), .resp_err(c_resp_err),
    .mem_req(c_mem_req), .mem_we(c_mem_we), .mem_addr(c_mem_addr),
    .mem_wdata(c_mem_wdata), .mem_wmask(c_mem_wmask), .mem_ack(c_mem_ack),
    .mem_rdata(c_mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard queues and monitors ----------------
  resp_t a_exp_resp[$];
  mem_t  a_exp_mem[$];
  int    a_resp_cnt = 0;
  int    a_last_len = 0;

  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (a_resp_valid) begin
        a_resp_cnt++;
        if (a_exp_resp.size() == 0) begin
          chk("resp_unexpected", 64'(a_resp_valid), 64'd0);
        end else begin
          e = a_exp_resp.pop_front();
          chk("resp_rdata", 64'(a_resp_rdata), 64'(e.rdata));
          chk("resp_err", 64'(a_resp_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    mem_t        e;
    logic        prev, stable;
    int          len;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wmask;
    logic        s_we;
    prev = 1'b0; stable = 1'b1; len = 0;
    s_addr = '0; s_wdata = '0; s_wmask = '0; s_we = 1'b0;
    forever begin
      @(negedge clk);
      if (a_mem_req && !prev) begin
        stable = 1'b1; len = 0;
        s_addr = a_mem_addr; s_we = a_mem_we; s_wdata = a_mem_wdata; s_wmask = a_mem_wmask;
        if (a_exp_mem.size() == 0) begin
          chk("mem_req_unexpected", 64'(a_mem_req), 64'd0);
        end else begin
          e = a_exp_mem.pop_front();
          chk("mem_addr", 64'(a_mem_addr), 64'(e.addr));
          chk("mem_we", 64'(a_mem_we), 64'(e.we));
          if (e.we) begin
            chk("mem_wdata", 64'(a_mem_wdata), 64'(e.wdata));
            chk("mem_wmask", 64'(a_mem_wmask), 64'(e.wmask));
          end
        end
      end
      if (a_mem_req) begin
        len++;
        if (a_mem_addr !== s_addr || a_mem_we !== s_we ||
            a_mem_wdata !== s_wdata || a_mem_wmask !== s_wmask) stable = 1'b0;
      end
      if (!a_mem_req && prev) begin
        chk("mem_stable", 64'(stable), 64'd1);
        a_last_len = len;
      end
      prev = a_mem_req;
    end
  end

  // ---------------- memory responder for A ----------------
  int   a_ack_delay = -1;
  int   a_wait_n    = 0;
  logic a_stray     = 1'b0;

  initial begin
    a_mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (a_mem_req) begin
        a_mem_ack = a_stray || (a_wait_n == a_ack_delay);
        a_wait_n++;
      end else begin
        a_mem_ack = a_stray;
        a_wait_n  = 0;
      end
    end
  end

  task automatic push_resp(input logic [31:0] rdata, input logic err);
    resp_t r;
    r.rdata = rdata; r.err = err;
    a_exp_resp.push_back(r);
  endtask

  task automatic push_mem(input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] wmask);
    mem_t m;
    m.addr = addr; m.we = we; m.wdata = wdata; m.wmask = wmask;
    a_exp_mem.push_back(m);
  endtask

  // Issue one request on A; lat_exp counts clock edges after the accepting edge
  // until resp_valid is visible (0 = response straight from IDLE).
  task automatic a_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int ack_delay, input int lat_exp, input logic has_mem);
    int   lat;
    logic hit;
    a_ack_delay = ack_delay;
    a_mem_rdata = rdata;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3;
    a_req_addr = addr; a_req_wdata = wdata;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_we = ~we; a_req_funct3 = 3'b111;
    a_req_addr = ~addr; a_req_wdata = ~wdata;
    hit = 1'b0; lat = 0;
    for (int i = 0; i < 64; i++) begin
      if (a_resp_valid) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("resp_seen", 64'(hit), 64'd1);
    if (hit) chk("resp_latency", 64'(lat), 64'(lat_exp));
    @(posedge clk); #1;
    if (has_mem && hit) chk("mem_req_cycles", 64'(a_last_len), 64'(lat_exp));
  endtask

  task automatic c_load(input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] rdata, input logic [63:0] exp, input logic exp_err);
    @(negedge clk);
    c_req_valid = 1'b1; c_req_we = 1'b0; c_req_funct3 = f3; c_req_addr = addr;
    c_mem_rdata = rdata;
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    if (!exp_err) begin
      chk("c_mem_req", 64'(c_mem_req), 64'd1);
      chk("c_mem_addr", 64'(c_mem_addr), 64'({addr[31:3], 3'b000}));
      c_mem_ack = 1'b1;
      @(posedge clk); #1;
      c_mem_ack = 1'b0;
    end else begin
      chk("c_no_mem_req", 64'(c_mem_req), 64'd0);
    end
    chk("c_resp_valid", 64'(c_resp_valid), 64'd1);
    chk("c_resp_rdata", c_resp_rdata, exp);
    chk("c_resp_err", 64'(c_resp_err), 64'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    int  cnt0;
    logic ok;
    rst = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_funct3 = '0; a_req_addr = '0; a_req_wdata = '0;
    a_mem_rdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = '0; b_req_addr = '0; b_req_wdata = '0;
    b_mem_ack = 1'b0; b_mem_rdata = '0;
    c_req_valid = 1'b0; c_req_we = 1'b0; c_req_funct3 = '0; c_req_addr = '0; c_req_wdata = '0;
    c_mem_ack = 1'b0; c_mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(a_req_ready), 64'd1);
    chk("rst_mem_req", 64'(a_mem_req), 64'd0);
    chk("rst_resp_valid", 64'(a_resp_valid), 64'd0);
    chk("rst_mem_addr", 64'(a_mem_addr), 64'd0);
    chk("rst_resp_rdata", 64'(a_resp_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // LB / LBU at byte 3, ack two cycles after mem_req rises
    push_mem(32'h8000_0000, 1'b0, '0, '0); push_resp(32'hFFFF_FF80, 1'b0);
    a_access(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 2, 3, 1'b1);
    push_mem(32'h8000_0000, 1'b0, '0, '0); push_resp(32'h0000_0080, 1'b0);
    a_access(1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_1234, 2, 3, 1'b1);
    // LH / LHU / LW, immediate ack
    push_mem(32'h8000_0000, 1'b0, '0, '0); push_resp(32'hFFFF_80FF, 1'b0);
    a_access(1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h80FF_1234, 0, 1, 1'b1);
    push_mem(32'h8000_0000, 1'b0, '0, '0); push_resp(32'h0000_8234, 1'b0);
    a_access(1'b0, 3'b101, 32'h8000_0000, 32'h0, 32'h80FF_8234, 0, 1, 1'b1);
    push_mem(32'h8000_0004, 1'b0, '0, '0); push_resp(32'hDEAD_BEEF, 1'b0);
    a_access(1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1, 2, 1'b1);
    // Stores: resp_rdata stays 0 even with nonzero mem_rdata
    push_mem(32'h8000_0000, 1'b1, 32'hABCD_0000, 4'b1100); push_resp(32'h0, 1'b0);
    a_access(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 2, 1'b1);
    push_mem(32'h8000_0000, 1'b1, 32'h0000_A500, 4'b0010); push_resp(32'h0, 1'b0);
    a_access(1'b1, 3'b000, 32'h8000_0001, 32'hFFFF_FFA5, 32'hFFFF_FFFF, 0, 1, 1'b1);
    push_mem(32'h8000_0008, 1'b1, 32'hCAFE_F00D, 4'b1111); push_resp(32'h0, 1'b0);
    a_access(1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 3, 4, 1'b1);
    // Misaligned LW
`ifdef YSYX_24100005_LSU_MISALIGN_TRAP_EN
    push_resp(32'h0, 1'b1);
    a_access(1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h1122_3344, 0, 0, 1'b0);
`else
    push_mem(32'h8000_0000, 1'b0, '0, '0); push_resp(32'h1122_3344, 1'b0);
    a_access(1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h1122_3344, 0, 1, 1'b1);
`endif
    // Illegal funct3 for XLEN=32: LD, LWU, 111, store 1xx, SD
    push_resp(32'h0, 1'b1); a_access(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h5555_5555, 0, 0, 1'b0);
    push_resp(32'h0, 1'b1); a_access(1'b0, 3'b110, 32'h8000_0000, 32'h0, 32'h5555_5555, 0, 0, 1'b0);
    push_resp(32'h0, 1'b1); a_access(1'b0, 3'b111, 32'h8000_0000, 32'h0, 32'h5555_5555, 0, 0, 1'b0);
    push_resp(32'h0, 1'b1); a_access(1'b1, 3'b100, 32'h8000_0000, 32'h1, 32'h5555_5555, 0, 0, 1'b0);
    push_resp(32'h0, 1'b1); a_access(1'b1, 3'b011, 32'h8000_0000, 32'h1, 32'h5555_5555, 0, 0, 1'b0);
    // Timeout: no ack, mem_req for exactly TIMEOUT=4 cycles
    push_mem(32'h8000_0010, 1'b0, '0, '0); push_resp(32'h0, 1'b1);
    a_access(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h7777_7777, -1, 4, 1'b1);

    // TIMEOUT=0 holds mem_req indefinitely
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_funct3 = 3'b010; b_req_addr = 32'h100;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    ok = 1'b1;
    repeat (1000) begin
      if (!b_mem_req || b_resp_valid) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("b_no_timeout", 64'(ok), 64'd1);

    // XLEN=64
    c_load(3'b011, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0);
    c_load(3'b010, 32'h8000_0004, 64'h8000_0000_1234_5678, 64'hFFFF_FFFF_8000_0000, 1'b0);
    c_load(3'b110, 32'h8000_0004, 64'h8000_0000_1234_5678, 64'h0000_0000_8000_0000, 1'b0);
    c_load(3'b111, 32'h8000_0000, 64'h1, 64'h0, 1'b1);

    // Asynchronous reset mid-BUSY, then a stray ack
    push_mem(32'h8000_0020, 1'b0, '0, '0);
    a_ack_delay = -1;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_funct3 = 3'b010; a_req_addr = 32'h8000_0020;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(posedge clk); #2;
    chk("busy_before_rst", 64'(a_mem_req), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_async_mem_req", 64'(a_mem_req), 64'd0);
    chk("rst_async_ready", 64'(a_req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    cnt0 = a_resp_cnt;
    @(posedge clk); #2;
    a_stray = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    a_stray = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stray_ack_no_resp", 64'(a_resp_cnt - cnt0), 64'd0);
    chk("post_rst_ready", 64'(a_req_ready), 64'd1);

    // Normal operation after reset
    push_mem(32'h8000_0000, 1'b0, '0, '0); push_resp(32'h0000_0012, 1'b0);
    a_access(1'b0, 3'b100, 32'h8000_0001, 32'h0, 32'hAB55_1234, 1, 2, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("resp_queue_empty", 64'(a_exp_resp.size()), 64'd0);
    chk("mem_queue_empty", 64'(a_exp_mem.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_lsu.md
YSYX_24100005_LSU -- requirements
Module: ysyx_24100005_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for mem_ack; 0 disables the timeout.
REQ-003 SHALL have ports clk in 1 (clock) and rst in 1 (reset): one clock, reset asynchronous and active-low.
REQ-004 req_valid in 1, core access request; req_ready out 1, LSU can accept.
REQ-005 req_we in 1, 1=store 0=load; req_funct3 in 3, RISC-V size/sign code; req_addr in 32, byte address; req_wdata in XLEN, store data (LSB-aligned).
REQ-006 resp_valid out 1, one-cycle completion pulse; resp_rdata out XLEN, extended load data; resp_err out 1, access fault.
REQ-007 mem_req out 1; mem_we out 1; mem_addr out 32; mem_wdata out XLEN; mem_wmask out XLEN/8; mem_ack in 1; mem_rdata in XLEN.

Function
REQ-008 SHALL use FSM IDLE -> BUSY -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-009 Acceptance is req_valid&req_ready at a clk edge; all req_* fields are latched then, and later input changes are ignored.
REQ-010 In BUSY, mem_req=1 and mem_addr/mem_we/mem_wdata/mem_wmask stay stable until the cycle mem_ack=1 is sampled; then go to RESP.
REQ-011 mem_ack outside BUSY SHALL be ignored.
REQ-012 RESP lasts exactly one cycle with resp_valid=1, then IDLE; minimum accept-to-resp_valid latency is 2 cycles (ack in the first BUSY cycle).
REQ-013 mem_addr = latched address with low log2(XLEN/8) bits cleared; offset = those low bits.
REQ-014 Loads: funct3 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; select the byte lane at offset from mem_rdata, then sign-extend (LB/LH/LW) or zero-extend (U forms) to XLEN.
REQ-015 Stores: funct3 000 SB, 001 SH, 010 SW, 011 SD; mem_wdata = size-truncated wdata shifted left by offset*8, other bits 0; mem_wmask = size-wide ones shifted left by offset.
REQ-016 Illegal funct3 (111; 011/110 load or 011 store when XLEN=32; store 1xx) SHALL skip BUSY, go IDLE->RESP, and return resp_err=1, resp_rdata=0.
REQ-017 A counter clears on BUSY entry and increments each BUSY cycle without ack. When TIMEOUT!=0 and the counter reaches TIMEOUT, the FSM SHALL drop mem_req, enter RESP with resp_err=1, resp_rdata=0.
REQ-018 For stores, resp_rdata=0. resp_rdata and resp_err are 0 whenever resp_valid=0.

Reset
REQ-019 rst low SHALL asynchronously force IDLE, counter=0, req_ready=1 (combinational from IDLE), and 0 on all other outputs, including mid-transaction. An in-flight access is abandoned, and an ack arriving after reset is ignored per REQ-011.

Configuration
REQ-020 Macro YSYX_24100005_LSU_MISALIGN_TRAP_EN defined: an access whose address is not size-aligned SHALL skip BUSY and respond with resp_err=1.
REQ-021 Macro undefined: misaligned access SHALL proceed with the address rounded down to size alignment; resp_err is never set for misalignment.

Structure
REQ-022 Package ysyx_24100005_lsu_pkg SHALL hold the FSM state typedef, funct3 encoding constants and size decode function.
REQ-023 Combinational sub-module ysyx_24100005_lsu_align SHALL implement store lane shift/mask and load extract/extend; the FSM and counter stay in ysyx_24100005_lsu.

Verification (XLEN=32 unless stated)
REQ-024 LB at 0x8000_0003, mem_rdata=0x80FF_1234, ack 2 cycles after mem_req rises -> mem_addr=0x8000_0000, resp_rdata=0xFFFF_FF80, resp_err=0. Repeat as LBU -> 0x0000_0080.
REQ-025 SH at 0x8000_0002, wdata=0x1234_ABCD -> mem_we=1, mem_wmask=4'b1100, mem_wdata=0xABCD_0000, resp_valid one cycle after ack with resp_rdata=0.
REQ-026 LW at 0x8000_0002 -> with macro: no mem_req, resp_err=1 one cycle after accept. Without macro: mem_addr=0x8000_0000, resp_err=0.
REQ-027 TIMEOUT=4, mem_ack held 0 -> mem_req high exactly 4 cycles, then resp_valid=1, resp_err=1. TIMEOUT=0 -> mem_req held for 1000 cycles with no response.
REQ-028 rst low during BUSY -> mem_req=0 without a clock edge. After release req_ready=1, and a stray mem_ack produces no resp_valid.
REQ-029 XLEN=64: LD at 0x8000_0008 returns mem_rdata unchanged; load funct3=111 -> resp_err=1 with no mem_req.
